// File: rtl/key_scan.sv
`default_nettype none
// ============================================================================
// Module   : key_scan
// Purpose  : 4x4 active-low keypad scanner with frame debounce, hex code out
//            and a 32-bit shift-in word of accepted codes.
// Revision : 1.0
// ============================================================================
module key_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row_i,
    input  logic        key_clr_i,
    output logic [3:0]  key_col_o,
    output logic [3:0]  key_code_o,
    output logic        key_valid_o,
    output logic        key_held_o,
    output logic [31:0] key_data_o
);

    localparam int                 c_div_w    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_max  = c_div_w'(SCAN_DIV - 1);
    localparam logic [3:0]         c_debounce = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_PRESS   = 2'd1,
        S_PRESSED      = 2'd2,
        S_WAIT_RELEASE = 2'd3
    } state_t;

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_col;
    logic [15:0]        r_frame;
    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [3:0]         r_cand;
    logic [3:0]         r_code;
    logic               r_valid;
    logic               r_held;
    logic [31:0]        r_data;

    logic               w_tick;
    logic               w_done;
    logic [15:0]        w_frame_next;
    logic [4:0]         w_nbits;
    logic [3:0]         w_idx;
    logic               w_empty;
    logic               w_single;
    logic [3:0]         w_cnt_inc;
    logic               w_accept;

    assign w_tick    = (r_div == c_div_max);
    assign w_done    = w_tick && (r_col == 2'd3);
    assign w_cnt_inc = r_cnt + 4'd1;

    // The column sampled on this edge is merged in so the completing sample is classified too.
    always_comb begin
        w_frame_next = r_frame;
        for (int r = 0; r < 4; r++) begin
            w_frame_next[{r[1:0], r_col}] = ~r_row_sync[r];
        end
        w_nbits = 5'd0;
        w_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame_next[i]) begin
                w_nbits = w_nbits + 5'd1;
                w_idx   = 4'(i);
            end
        end
    end

    assign w_empty  = (w_nbits == 5'd0);
    assign w_single = (w_nbits == 5'd1);
    assign w_accept = w_done && (r_state == S_WAIT_PRESS) && w_single &&
                      (w_idx == r_cand) && (w_cnt_inc == c_debounce);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
            r_div      <= '0;
            r_col      <= 2'd0;
            r_frame    <= 16'h0;
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_cand     <= 4'd0;
            r_code     <= 4'd0;
            r_valid    <= 1'b0;
            r_held     <= 1'b0;
            r_data     <= 32'h0;
        end else begin
            r_row_meta <= key_row_i;
            r_row_sync <= r_row_meta;
            r_div      <= w_tick ? '0 : r_div + 1'b1;
            r_valid    <= w_accept;

            if (w_tick) begin
                r_col   <= r_col + 2'd1;
                r_frame <= w_frame_next;
            end

            // Clear takes effect before the shift when both happen together.
            if (w_accept) begin
                r_data <= {(key_clr_i ? 28'h0 : r_data[27:0]), r_cand};
                r_code <= r_cand;
            end else if (key_clr_i) begin
                r_data <= 32'h0;
            end

            if (w_done) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_single) begin
                            r_state <= S_WAIT_PRESS;
                            r_cand  <= w_idx;
                            r_cnt   <= 4'd1;
                        end
                    end
                    S_WAIT_PRESS: begin
                        if (w_single && (w_idx == r_cand)) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == c_debounce) begin
                                r_state <= S_PRESSED;
                                r_held  <= 1'b1;
                            end
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= 4'd0;
                        end
                    end
                    S_PRESSED: begin
                        if (w_empty) begin
                            r_state <= S_WAIT_RELEASE;
                            r_cnt   <= 4'd1;
                        end
                    end
                    S_WAIT_RELEASE: begin
                        if (w_empty) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == c_debounce) begin
                                r_state <= S_IDLE;
                                r_held  <= 1'b0;
                                r_cnt   <= 4'd0;
                            end
                        end else begin
                            r_state <= S_PRESSED;
                            r_cnt   <= 4'd0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign key_col_o   = ~(4'b0001 << r_col);
    assign key_code_o  = r_code;
    assign key_valid_o = r_valid;
    assign key_held_o  = r_held;
    assign key_data_o  = r_data;

endmodule
`default_nettype wire
